// File: rtl/stop_watch_lap.sv
// Stopwatch / countdown timer core with hour:min:sec:msec fields and a small lap buffer.
// Control inputs are single-cycle pulses; lap readback is registered with one clock of latency.
module stop_watch_lap #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int HOUR_MOD    = 24,
    parameter int LAP_DEPTH   = 4,
    localparam int PTR_W      = $clog2(LAP_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run_stop,
    input  logic             i_clear,
    input  logic             i_lap,
    input  logic             i_load,
    input  logic             i_mode,
    input  logic [23:0]      i_load_time,
    input  logic [PTR_W-1:0] i_lap_sel,
    output logic [6:0]       msec,
    output logic [5:0]       sec,
    output logic [5:0]       min,
    output logic [4:0]       hour,
    output logic             o_running,
    output logic             o_done,
    output logic [23:0]      o_lap_time,
    output logic [PTR_W:0]   o_lap_cnt
);

    localparam int PRESC_MAX = CLK_FREQ_HZ / TICK_HZ - 1;
    localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam logic [6:0] MSEC_MAX = 7'(TICK_HZ - 1);
    localparam logic [4:0] HOUR_MAX = 5'(HOUR_MOD - 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DONE} state_t;

    state_t             state_reg, state_next;
    logic               mode_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic [6:0]         msec_reg, msec_next;
    logic [5:0]         sec_reg, sec_next, min_reg, min_next;
    logic [4:0]         hour_reg, hour_next;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W:0]     lap_cnt_reg;
    logic [23:0]        lap_rd_reg;
    logic [23:0]        lap_mem [LAP_DEPTH];

    logic tick, eff_mode, time_zero, time_last, do_load, do_lap;
    logic [PTR_W-1:0] rd_idx;

    // In STOP the mode follows i_mode live, so a start pulse uses the mode it will latch.
    assign eff_mode  = (state_reg == ST_STOP) ? i_mode : mode_reg;
    assign tick      = (state_reg == ST_RUN) && (presc_reg == PRESC_W'(PRESC_MAX));
    assign time_zero = (hour_reg == '0) && (min_reg == '0) && (sec_reg == '0) && (msec_reg == '0);
    assign time_last = (hour_reg == '0) && (min_reg == '0) && (sec_reg == '0) && (msec_reg == 7'd1);
    assign do_load   = !i_clear && i_load && (state_reg == ST_STOP);
    assign do_lap    = !i_clear && i_lap && (state_reg == ST_RUN);
    assign rd_idx    = wr_ptr_reg - PTR_W'(1) - i_lap_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_STOP;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_STOP: if (!i_load && i_run_stop && !(eff_mode && time_zero)) state_next = ST_RUN;
            ST_RUN: begin
                if (i_run_stop)
                    state_next = ST_STOP;
                else if (tick && mode_reg && (time_last || time_zero))
                    state_next = ST_DONE;
            end
            ST_DONE: if (i_run_stop) state_next = ST_STOP;
            default: state_next = ST_STOP;
        endcase
        if (i_clear) state_next = ST_STOP;
    end

    always_comb begin
        o_running = (state_reg == ST_RUN);
        o_done    = (state_reg == ST_DONE);
    end

    // Time field update: clear, clipped load, then up/down carry chains on tick.
    always_comb begin
        msec_next = msec_reg;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hour_next = hour_reg;
        if (i_clear) begin
            msec_next = '0; sec_next = '0; min_next = '0; hour_next = '0;
        end else if (do_load) begin
            hour_next = (i_load_time[23:19] > HOUR_MAX) ? HOUR_MAX : i_load_time[23:19];
            min_next  = (i_load_time[18:13] > 6'd59)    ? 6'd59    : i_load_time[18:13];
            sec_next  = (i_load_time[12:7]  > 6'd59)    ? 6'd59    : i_load_time[12:7];
            msec_next = (i_load_time[6:0]   > MSEC_MAX) ? MSEC_MAX : i_load_time[6:0];
        end else if (tick) begin
            if (mode_reg) begin
                if (!time_zero) begin
                    if (msec_reg != '0) msec_next = msec_reg - 7'd1;
                    else begin
                        msec_next = MSEC_MAX;
                        if (sec_reg != '0) sec_next = sec_reg - 6'd1;
                        else begin
                            sec_next = 6'd59;
                            if (min_reg != '0) min_next = min_reg - 6'd1;
                            else begin
                                min_next  = 6'd59;
                                hour_next = hour_reg - 5'd1;
                            end
                        end
                    end
                end
            end else begin
                if (msec_reg != MSEC_MAX) msec_next = msec_reg + 7'd1;
                else begin
                    msec_next = '0;
                    if (sec_reg != 6'd59) sec_next = sec_reg + 6'd1;
                    else begin
                        sec_next = '0;
                        if (min_reg != 6'd59) min_next = min_reg + 6'd1;
                        else begin
                            min_next  = '0;
                            hour_next = (hour_reg == HOUR_MAX) ? 5'd0 : hour_reg + 5'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msec_reg    <= '0;
            sec_reg     <= '0;
            min_reg     <= '0;
            hour_reg    <= '0;
            mode_reg    <= 1'b0;
            presc_reg   <= '0;
            wr_ptr_reg  <= '0;
            lap_cnt_reg <= '0;
            lap_rd_reg  <= '0;
        end else begin
            msec_reg <= msec_next;
            sec_reg  <= sec_next;
            min_reg  <= min_next;
            hour_reg <= hour_next;
            if (state_reg == ST_STOP) mode_reg <= i_mode;
            if (i_clear || do_load)         presc_reg <= '0;
            else if (state_reg == ST_RUN)   presc_reg <= tick ? '0 : presc_reg + PRESC_W'(1);
            if (i_clear) begin
                wr_ptr_reg  <= '0;
                lap_cnt_reg <= '0;
            end else if (do_lap) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (lap_cnt_reg != (PTR_W+1)'(LAP_DEPTH)) lap_cnt_reg <= lap_cnt_reg + (PTR_W+1)'(1);
            end
            lap_rd_reg <= ({1'b0, i_lap_sel} < lap_cnt_reg) ? lap_mem[rd_idx] : 24'd0;
        end
    end

    // Lap storage captures the pre-tick time; kept reset-free so it maps to RAM.
    always_ff @(posedge clk) begin
        if (do_lap) lap_mem[wr_ptr_reg] <= {hour_reg, min_reg, sec_reg, msec_reg};
    end

    assign msec       = msec_reg;
    assign sec        = sec_reg;
    assign min        = min_reg;
    assign hour       = hour_reg;
    assign o_lap_time = lap_rd_reg;
    assign o_lap_cnt  = lap_cnt_reg;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Directed testbench for stop_watch_lap with a 10-clock tick (CLK_FREQ_HZ=1000, TICK_HZ=100).
module tb_stop_watch_lap;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_run_stop = 0, i_clear = 0, i_lap = 0, i_load = 0, i_mode = 0;
    logic [23:0] i_load_time = '0;
    logic [1:0]  i_lap_sel = '0;
    logic [6:0]  msec;
    logic [5:0]  sec, min;
    logic [4:0]  hour;
    logic        o_running, o_done;
    logic [23:0] o_lap_time;
    logic [2:0]  o_lap_cnt;
    logic [23:0] cur_time;

    int n_checks = 0;
    int n_errors = 0;

    stop_watch_lap #(
        .CLK_FREQ_HZ(1000), .TICK_HZ(100), .HOUR_MOD(24), .LAP_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .i_run_stop(i_run_stop), .i_clear(i_clear), .i_lap(i_lap),
        .i_load(i_load), .i_mode(i_mode), .i_load_time(i_load_time), .i_lap_sel(i_lap_sel),
        .msec(msec), .sec(sec), .min(min), .hour(hour), .o_running(o_running),
        .o_done(o_done), .o_lap_time(o_lap_time), .o_lap_cnt(o_lap_cnt)
    );

    always #5 clk = ~clk;
    assign cur_time = {hour, min, sec, msec};

    function automatic logic [23:0] pack(input int h, input int m, input int s, input int ms);
        return {5'(h), 6'(m), 6'(s), 7'(ms)};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; asserts the selected pulses across exactly one rising edge.
    task automatic pulse(input bit rs, input bit cl, input bit lp, input bit ld);
        i_run_stop = rs; i_clear = cl; i_lap = lp; i_load = ld;
        @(negedge clk);
        i_run_stop = 0; i_clear = 0; i_lap = 0; i_load = 0;
    endtask

    initial begin
        wait_clk(3);
        check_val("rst_time", 32'(cur_time), 32'd0);
        check_val("rst_run", 32'(o_running), 32'd0);
        rst = 1'b1;
        wait_clk(1);
        check_val("rst_cnt", 32'(o_lap_cnt), 32'd0);

        // 1: count up 1 s, stop freezes time and prescaler
        pulse(1, 0, 0, 0);
        wait_clk(1000);
        check_val("t1_time", 32'(cur_time), 32'(pack(0, 0, 1, 0)));
        check_val("t1_run", 32'(o_running), 32'd1);
        pulse(1, 0, 0, 0);
        wait_clk(30);
        check_val("t1_frozen", 32'(cur_time), 32'(pack(0, 0, 1, 0)));
        check_val("t1_stopped", 32'(o_running), 32'd0);
        pulse(1, 0, 0, 0);
        wait_clk(8);
        check_val("t1_presc_hold_a", 32'(msec), 32'd0);
        wait_clk(1);
        check_val("t1_presc_hold_b", 32'(msec), 32'd1);
        pulse(1, 0, 0, 0);

        // 2: full wrap from 23:59:59.98
        i_load_time = pack(23, 59, 59, 98);
        pulse(0, 0, 0, 1);
        check_val("t2_load", 32'(cur_time), 32'(pack(23, 59, 59, 98)));
        pulse(1, 0, 0, 0);
        wait_clk(19);
        check_val("t2_mid", 32'(cur_time), 32'(pack(23, 59, 59, 99)));
        wait_clk(1);
        check_val("t2_wrap", 32'(cur_time), 32'd0);
        check_val("t2_run", 32'(o_running), 32'd1);
        pulse(1, 0, 0, 0);

        // 3: countdown 1 s to DONE
        i_mode = 1'b1;
        i_load_time = pack(0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        wait_clk(999);
        check_val("t3_last", 32'(cur_time), 32'(pack(0, 0, 0, 1)));
        wait_clk(1);
        check_val("t3_zero", 32'(cur_time), 32'd0);
        check_val("t3_done", 32'(o_done), 32'd1);
        check_val("t3_notrun", 32'(o_running), 32'd0);
        pulse(1, 0, 0, 0);
        check_val("t3_stop_done", 32'(o_done), 32'd0);
        pulse(1, 0, 0, 0);
        check_val("t3_ignored", 32'(o_running), 32'd0);

        // 4: five laps into a 4-deep buffer
        i_mode = 1'b0;
        pulse(1, 0, 0, 0);
        wait_clk(14);
        pulse(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            wait_clk(9);
            pulse(0, 0, 1, 0);
        end
        pulse(1, 0, 0, 0);
        check_val("t4_cnt", 32'(o_lap_cnt), 32'd4);
        pulse(0, 0, 1, 0);
        check_val("t4_lap_in_stop", 32'(o_lap_cnt), 32'd4);
        for (int s = 0; s < 4; s++) begin
            i_lap_sel = 2'(s);
            wait_clk(1);
            check_val($sformatf("t4_sel%0d", s), 32'(o_lap_time), 32'(pack(0, 0, 0, 5 - s)));
        end

        // 5: clear beats run_stop; load beats run_stop; clipping; run_stop+lap
        i_lap_sel = 2'd0;
        pulse(1, 0, 0, 0);
        wait_clk(5);
        pulse(1, 1, 0, 0);
        check_val("t5_clr_run", 32'(o_running), 32'd0);
        check_val("t5_clr_time", 32'(cur_time), 32'd0);
        check_val("t5_clr_cnt", 32'(o_lap_cnt), 32'd0);
        wait_clk(1);
        check_val("t5_clr_lap", 32'(o_lap_time), 32'd0);
        i_load_time = pack(1, 2, 3, 4);
        pulse(1, 0, 0, 1);
        check_val("t5_load", 32'(cur_time), 32'(pack(1, 2, 3, 4)));
        check_val("t5_load_stop", 32'(o_running), 32'd0);
        i_load_time = 24'hFFFFFF;
        pulse(0, 0, 0, 1);
        check_val("t5_clip", 32'(cur_time), 32'(pack(23, 59, 59, 99)));
        pulse(1, 0, 0, 0);
        wait_clk(2);
        pulse(1, 0, 1, 0);
        check_val("t5_rs_lap_stop", 32'(o_running), 32'd0);
        check_val("t5_rs_lap_cnt", 32'(o_lap_cnt), 32'd1);
        wait_clk(1);
        check_val("t5_rs_lap_val", 32'(o_lap_time), 32'(pack(23, 59, 59, 99)));
        i_lap_sel = 2'd1;
        wait_clk(1);
        check_val("t5_sel_beyond", 32'(o_lap_time), 32'd0);

        // 6: asynchronous reset mid-run
        i_lap_sel = 2'd0;
        pulse(1, 0, 0, 0);
        wait_clk(25);
        #2 rst = 1'b0;
        #1;
        check_val("t6_time", 32'(cur_time), 32'd0);
        check_val("t6_run", 32'(o_running), 32'd0);
        check_val("t6_lap", 32'(o_lap_time), 32'd0);
        check_val("t6_cnt", 32'(o_lap_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_clk(30);
        check_val("t6_idle", 32'(cur_time), 32'd0);
        pulse(1, 0, 0, 0);
        wait_clk(9);
        check_val("t6_pre_tick", 32'(msec), 32'd0);
        wait_clk(1);
        check_val("t6_first_tick", 32'(msec), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
